// File: rtl/axil_slave_hs_pkg.sv
// Shared response codes, FSM encodings and alignment helper for the AXI4-Lite request/ack slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // AW and W may arrive in either order; each is remembered until both are present.
  typedef struct packed {
    logic aw;
    logic w;
  } w_held_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  function automatic logic is_misaligned(input logic [2:0] addr_lo, input int unsigned align_w);
    logic [2:0] mask;
    mask = 3'((1 << align_w) - 1);
    return |(addr_lo & mask);
  endfunction

endpackage

// File: rtl/axil_slave_hs_if.sv
// AXI4-Lite slave port plus the user-side request/acknowledge bus, bundled for the slave controller.
interface axil_slave_hs_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  logic                  user_wr_req;
  logic [ADDR_WIDTH-1:0] user_wr_addr;
  logic [DATA_WIDTH-1:0] user_wr_data;
  logic [STRB_W-1:0]     user_wr_strb;
  logic                  user_wr_ack;
  logic                  user_wr_err;
  logic                  user_rd_req;
  logic [ADDR_WIDTH-1:0] user_rd_addr;
  logic                  user_rd_ack;
  logic                  user_rd_err;
  logic [DATA_WIDTH-1:0] user_rd_data;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  user_wr_ack, user_wr_err, user_rd_ack, user_rd_err, user_rd_data,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    output user_wr_req, user_wr_addr, user_wr_data, user_wr_strb, user_rd_req, user_rd_addr
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output user_wr_ack, user_wr_err, user_rd_ack, user_rd_err, user_rd_data,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
    input  user_wr_req, user_wr_addr, user_wr_data, user_wr_strb, user_rd_req, user_rd_addr
  );

endinterface

// File: rtl/axil_slave_hs_req_timer.sv
// Request watchdog: counts cycles while run_i is high, flags the last allowed cycle.
// Only built with AXIL_TIMEOUT_EN defined.
`ifdef AXIL_TIMEOUT_EN
module axil_req_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expire_c
);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  // Dropping run_i clears the count, so every request starts from zero.
  always_comb begin
    count_d = '0;
    if (run_i) count_d = count_q + CNT_W'(1);
  end

  assign expire_c = run_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule
`endif

// File: rtl/axil_slave_hs.sv
// AXI4-Lite slave bridging to a user request/ack bus with independent write and read FSMs.
// Define AXIL_TIMEOUT_EN to abort requests the user side leaves unacknowledged.
module axil_slave_hs
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            aclk,
  input logic            aresetn,
  axil_slave_hs_if.slave axil
);
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned ALIGN_W = $clog2(STRB_W);

  if (TIMEOUT_CYCLES < 2 || !(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_cfg
    $error("axil_slave_hs: DATA_WIDTH must be 32/64 and TIMEOUT_CYCLES >= 2");
  end

  // ---------------- write path ----------------
  w_state_e              w_state_q, w_state_d;
  w_held_t               w_held_q, w_held_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d, user_wr_req_q, user_wr_req_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, wr_addr_sel_c;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0]     wr_strb_q, wr_strb_d;
  logic                  aw_hs_c, w_hs_c, b_hs_c, wr_done_c, wr_mis_c, wr_expire_c;

  assign aw_hs_c       = axil.awvalid & awready_q;
  assign w_hs_c        = axil.wvalid & wready_q;
  assign b_hs_c        = bvalid_q & axil.bready;
  assign wr_done_c     = (w_state_q == W_REQ) & (axil.user_wr_ack | wr_expire_c);
  assign wr_addr_sel_c = aw_hs_c ? axil.awaddr : wr_addr_q;
  assign wr_mis_c      = is_misaligned(3'(wr_addr_sel_c), ALIGN_W);

  always_comb begin
    w_state_d = w_state_q;
    w_held_d  = w_held_q;
    case (w_state_q)
      W_IDLE: begin
        w_held_d.aw = w_held_q.aw | aw_hs_c;
        w_held_d.w  = w_held_q.w | w_hs_c;
        if (w_held_d.aw && w_held_d.w) begin
          w_held_d  = '0;
          w_state_d = wr_mis_c ? W_RESP : W_REQ;
        end
      end
      W_REQ:   if (wr_done_c) w_state_d = W_RESP;
      W_RESP:  if (b_hs_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready_d     = (w_state_d == W_IDLE) && !w_held_d.aw;
    wready_d      = (w_state_d == W_IDLE) && !w_held_d.w;
    user_wr_req_d = (w_state_d == W_REQ);
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    wr_addr_d     = wr_addr_sel_c;
    wr_data_d     = w_hs_c ? axil.wdata : wr_data_q;
    wr_strb_d     = w_hs_c ? axil.wstrb : wr_strb_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_state_d == W_RESP) begin
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
        end
      end
      W_REQ: begin
        // A same-cycle ack beats the watchdog.
        if (wr_done_c) begin
          bvalid_d = 1'b1;
          bresp_d  = (axil.user_wr_ack && !axil.user_wr_err) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP:  if (b_hs_c) bvalid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q     <= W_IDLE;
      w_held_q      <= '0;
      awready_q     <= 1'b0;
      wready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
      bresp_q       <= RESP_OKAY;
      user_wr_req_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_strb_q     <= '0;
    end else begin
      w_state_q     <= w_state_d;
      w_held_q      <= w_held_d;
      awready_q     <= awready_d;
      wready_q      <= wready_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      user_wr_req_q <= user_wr_req_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_strb_q     <= wr_strb_d;
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  user_rd_req_q, user_rd_req_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  ar_hs_c, r_hs_c, rd_done_c, rd_mis_c, rd_expire_c;

  assign ar_hs_c   = axil.arvalid & arready_q;
  assign r_hs_c    = rvalid_q & axil.rready;
  assign rd_done_c = (r_state_q == R_REQ) & (axil.user_rd_ack | rd_expire_c);
  assign rd_mis_c  = is_misaligned(3'(axil.araddr), ALIGN_W);

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_c) r_state_d = rd_mis_c ? R_RESP : R_REQ;
      R_REQ:   if (rd_done_c) r_state_d = R_RESP;
      R_RESP:  if (r_hs_c) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d     = (r_state_d == R_IDLE);
    user_rd_req_d = (r_state_d == R_REQ);
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    rd_addr_d     = ar_hs_c ? axil.araddr : rd_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c && rd_mis_c) begin
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = '0;
        end
      end
      R_REQ: begin
        if (rd_done_c) begin
          rvalid_d = 1'b1;
          if (axil.user_rd_ack) begin
            rdata_d = axil.user_rd_data;
            rresp_d = axil.user_rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_RESP:  if (r_hs_c) rvalid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q     <= R_IDLE;
      arready_q     <= 1'b0;
      rvalid_q      <= 1'b0;
      rresp_q       <= RESP_OKAY;
      rdata_q       <= '0;
      user_rd_req_q <= 1'b0;
      rd_addr_q     <= '0;
    end else begin
      r_state_q     <= r_state_d;
      arready_q     <= arready_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      user_rd_req_q <= user_rd_req_d;
      rd_addr_q     <= rd_addr_d;
    end
  end

`ifdef AXIL_TIMEOUT_EN
  axil_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timer (
    .clk      (aclk),
    .rst_n    (aresetn),
    .run_i    (w_state_q == W_REQ),
    .expire_c (wr_expire_c)
  );
  axil_req_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timer (
    .clk      (aclk),
    .rst_n    (aresetn),
    .run_i    (r_state_q == R_REQ),
    .expire_c (rd_expire_c)
  );
`else
  assign wr_expire_c = 1'b0;
  assign rd_expire_c = 1'b0;
`endif

  assign axil.awready      = awready_q;
  assign axil.wready       = wready_q;
  assign axil.bvalid       = bvalid_q;
  assign axil.bresp        = bresp_q;
  assign axil.user_wr_req  = user_wr_req_q;
  assign axil.user_wr_addr = wr_addr_q;
  assign axil.user_wr_data = wr_data_q;
  assign axil.user_wr_strb = wr_strb_q;
  assign axil.arready      = arready_q;
  assign axil.rvalid       = rvalid_q;
  assign axil.rresp        = rresp_q;
  assign axil.rdata        = rdata_q;
  assign axil.user_rd_req  = user_rd_req_q;
  assign axil.user_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axil_slave_hs.sv
// Directed plus randomized bench for axil_slave_hs against a word-addressed memory reference model.
module tb_axil_slave_hs;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_slave_hs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_slave_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk    (clk),
    .aresetn (rst_n),
    .axil    (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] mem [logic [31:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response rule: anything but an acknowledged, error-free access is SLVERR.
  function automatic logic [1:0] exp_resp(input bit mis, input bit acked, input bit err);
    return (mis || !acked || err) ? 2'b10 : 2'b00;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int ack_dly, input bit err,
                           input int b_dly);
    bit aw_done, w_done, aw_fire, w_fire, mis, acked;
    int t, i;
    logic [1:0] er;
    logic [31:0] word;
    aw_done = 0; w_done = 0; acked = 0; t = 0;
    mis = (addr[1:0] != 2'b00);
    while (!(aw_done && w_done)) begin
      if (t > 40) begin
        chk("wr_hs_bound", 64'({aw_done, w_done}), 64'(2'b11));
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        return;
      end
      bus.awvalid = !aw_done && (t >= aw_dly); bus.awaddr = addr;
      bus.wvalid  = !w_done && (t >= w_dly);   bus.wdata = data; bus.wstrb = strb;
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      step(); t++;
      aw_done = aw_done | aw_fire;
      w_done  = w_done | w_fire;
      if (w_done && !aw_done) chk("wready_after_w", bus.wready, 0);
      if (aw_done && !w_done) chk("awready_after_aw", bus.awready, 0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("wr_busy_ready", {bus.awready, bus.wready}, 0);
    if (mis) begin
      chk("wr_mis_noreq", bus.user_wr_req, 0);
    end else begin
      chk("wr_req_on", bus.user_wr_req, 1);
      chk("wr_req_addr", bus.user_wr_addr, addr);
      chk("wr_req_data", bus.user_wr_data, data);
      chk("wr_req_strb", bus.user_wr_strb, strb);
      chk("wr_early_bvalid", bus.bvalid, 0);
      i = 0;
      forever begin
`ifdef AXIL_TIMEOUT_EN
        if (i == TMO) break;
`endif
        chk("wr_req_held", bus.user_wr_req, 1);
        if (i == ack_dly) begin
          bus.user_wr_ack = 1'b1; bus.user_wr_err = err;
          step();
          bus.user_wr_ack = 1'b0; bus.user_wr_err = 1'b0;
          acked = 1;
          break;
        end
        step(); i++;
      end
      if (acked && !err) begin
        word = mem.exists(addr) ? mem[addr] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
        mem[addr] = word;
      end
    end
    er = exp_resp(mis, acked, err);
    chk("wr_bvalid", bus.bvalid, 1);
    chk("wr_bresp", bus.bresp, er);
    chk("wr_req_dropped", bus.user_wr_req, 0);
    for (int k = 0; k < b_dly; k++) begin
      step();
      chk("wr_bvalid_hold", bus.bvalid, 1);
      chk("wr_bresp_hold", bus.bresp, er);
    end
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    chk("wr_bvalid_clear", bus.bvalid, 0);
    chk("wr_ready_again", {bus.awready, bus.wready}, 2'b11);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int ack_dly, input bit err,
                          input int r_dly, input logic [31:0] rd_val);
    bit ar_done, ar_fire, mis, acked;
    int t, i;
    logic [1:0] er;
    logic [31:0] ed;
    ar_done = 0; acked = 0; t = 0;
    mis = (addr[1:0] != 2'b00);
    while (!ar_done) begin
      if (t > 40) begin
        chk("rd_hs_bound", 64'(ar_done), 64'(1));
        bus.arvalid = 1'b0;
        return;
      end
      bus.arvalid = (t >= ar_dly); bus.araddr = addr;
      ar_fire = bus.arvalid && bus.arready;
      step(); t++;
      ar_done = ar_fire;
    end
    bus.arvalid = 1'b0;
    chk("rd_busy_arready", bus.arready, 0);
    if (mis) begin
      chk("rd_mis_noreq", bus.user_rd_req, 0);
    end else begin
      chk("rd_req_on", bus.user_rd_req, 1);
      chk("rd_req_addr", bus.user_rd_addr, addr);
      chk("rd_early_rvalid", bus.rvalid, 0);
      i = 0;
      forever begin
`ifdef AXIL_TIMEOUT_EN
        if (i == TMO) break;
`endif
        chk("rd_req_held", bus.user_rd_req, 1);
        if (i == ack_dly) begin
          bus.user_rd_ack = 1'b1; bus.user_rd_err = err; bus.user_rd_data = rd_val;
          step();
          bus.user_rd_ack = 1'b0; bus.user_rd_err = 1'b0; bus.user_rd_data = $urandom;
          acked = 1;
          break;
        end
        step(); i++;
      end
    end
    er = exp_resp(mis, acked, err);
    ed = (mis || !acked) ? 32'h0 : rd_val;
    chk("rd_rvalid", bus.rvalid, 1);
    chk("rd_rresp", bus.rresp, er);
    chk("rd_rdata", bus.rdata, ed);
    chk("rd_req_dropped", bus.user_rd_req, 0);
    for (int k = 0; k < r_dly; k++) begin
      step();
      chk("rd_rvalid_hold", bus.rvalid, 1);
      chk("rd_rdata_hold", bus.rdata, ed);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    chk("rd_rvalid_clear", bus.rvalid, 0);
    chk("rd_arready_again", bus.arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion expected $finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, ra, rv;
    int ackd;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    bus.user_wr_ack = 0; bus.user_wr_err = 0;
    bus.user_rd_ack = 0; bus.user_rd_err = 0; bus.user_rd_data = '0;

    // Reset state
    step(); step();
    chk("rst_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
                     bus.rresp, bus.user_wr_req, bus.user_rd_req}, 0);
    chk("rst_payload", |{bus.rdata, bus.user_wr_addr, bus.user_wr_data, bus.user_wr_strb,
                         bus.user_rd_addr}, 0);
    rst_n = 1'b1;
    step();
    chk("idle_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);

    // Directed cases
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0);
    axi_write(32'h20, 32'hCAFEF00D, 4'h5, 3, 0, 2, 0, 1);
    axi_read(32'h04, 0, 5, 1, 4, 32'h12345678);
    axi_write(32'h03, 32'h11111111, 4'hF, 0, 0, 0, 0, 1);
    axi_read(32'h06, 0, 0, 0, 1, 32'h22222222);
    axi_read(32'h10, 1, 1, 0, 0, mem[32'h10]);
`ifdef AXIL_TIMEOUT_EN
    axi_write(32'h30, 32'h33333333, 4'hF, 0, 0, 1000, 0, 0);
    axi_read(32'h34, 0, 1000, 0, 0, 32'h44444444);
    axi_write(32'h38, 32'h55555555, 4'hF, 0, 0, TMO - 1, 0, 0);
    axi_read(32'h38, 0, TMO - 1, 0, 0, 32'h66666666);
`endif

    // Independent paths active together
    fork
      axi_write(32'h40, 32'hA1B2C3D4, 4'hF, 1, 0, 2, 0, 1);
      axi_read(32'h44, 0, 1, 0, 2, 32'h0BADF00D);
    join

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      ackd = $urandom_range(0, 6);
`ifdef AXIL_TIMEOUT_EN
      if ($urandom_range(0, 4) == 0) ackd = $urandom_range(TMO - 2, TMO + 4);
`endif
      axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ackd,
                ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
      ra = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 5) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      rv = mem.exists(ra) ? mem[ra] : $urandom;
      axi_read(ra, $urandom_range(0, 3), $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 3), rv);
    end

    // Reset while write is in W_REQ and read is in R_RESP
    bus.awaddr = 32'h50; bus.awvalid = 1; bus.wdata = 32'h77777777; bus.wstrb = 4'hF; bus.wvalid = 1;
    bus.araddr = 32'h54; bus.arvalid = 1;
    step();
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    chk("mid_reqs", {bus.user_wr_req, bus.user_rd_req}, 2'b11);
    bus.user_rd_ack = 1; bus.user_rd_data = 32'hA5A5A5A5;
    step();
    bus.user_rd_ack = 0;
    chk("mid_state", {bus.rvalid, bus.user_wr_req}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.bresp, bus.arready, bus.rvalid,
                           bus.rresp, bus.user_wr_req, bus.user_rd_req}, 0);
    chk("async_rst_payload", |{bus.rdata, bus.user_wr_addr, bus.user_wr_data, bus.user_wr_strb,
                               bus.user_rd_addr}, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}, 5'b11100);
    axi_write(32'h60, 32'h89ABCDEF, 4'hF, 0, 0, 1, 0, 0);
    axi_read(32'h60, 0, 0, 0, 0, mem[32'h60]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_slave_hs.md
# axil_slave_hs

Parametrised AXI4-Lite slave controller, successor to the fixed-timing AXI-Lite slave. It turns AXI-Lite requests into a user-side request/acknowledge bus, so register files and peripherals of any latency can sit behind it. It also checks address alignment and can optionally time out unresponsive user logic, returning SLVERR in both cases. It sits between the AXI-Lite interconnect port and the local register/memory block.

## Interface
- ADDR_WIDTH, 32, AXI/user address width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- TIMEOUT_CYCLES, 16, user-ack wait limit in cycles, ≥2; used only with AXIL_TIMEOUT_EN.
- aclk  in  1  single clock, all logic rising-edge.
- aresetn  in  1  reset, asynchronous active-low.
- awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  AXI write address channel.
- wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI write data channel.
- bresp/bvalid/bready  out/out/in  2/1/1  AXI write response channel.
- araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  AXI read address channel.
- rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  AXI read data channel.
- user_wr_req  out  1  write request, held until ack.
- user_wr_addr/user_wr_data/user_wr_strb  out  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  latched write payload.
- user_wr_ack/user_wr_err  in  1/1  write completion; err is valid with ack.
- user_rd_req  out  1  read request, held until ack.
- user_rd_addr  out  ADDR_WIDTH  latched read address.
- user_rd_ack/user_rd_err/user_rd_data  in  1/1/DATA_WIDTH  read completion; err and data are valid with ack.

## Operation
- Write and read paths are fully independent and may be active in the same cycle.
- Write FSM states:
  - W_IDLE: awready = no AW held; wready = no W held. AW and W handshakes are captured in any order, including the same cycle.
  - When both are held: an aligned address goes to W_REQ; a misaligned address (low log2(DATA_WIDTH/8) bits ≠ 0) goes to W_RESP with SLVERR and no user request.
  - W_REQ: user_wr_req=1. On user_wr_ack, bresp = err ? 2'b10 : 2'b00, then go to W_RESP.
  - W_RESP: bvalid=1, bresp stable. On bready, go to W_IDLE.
  - awready and wready are 0 in W_REQ and W_RESP.
- Read FSM states:
  - R_IDLE: arready=1. On handshake, capture araddr. Aligned → R_REQ; misaligned → R_RESP with SLVERR and rdata=0.
  - R_REQ: user_rd_req=1. On user_rd_ack, register user_rd_data and rresp, then go to R_RESP.
  - R_RESP: rvalid=1, rdata and rresp stable. On rready, go to R_IDLE.
- An ack arriving with no request outstanding is ignored.
- Reset values: every output 0; bresp=rresp=2'b00; all payload registers 0; both FSMs in IDLE.
- Reset mid-transaction abandons it; no response is issued.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request asserts the cycle after the last address/data handshake.
- Ack sampled in the first request cycle gives the response on the next cycle. Minimum latency, handshake to valid response: 2 cycles for write and for read.
- Request deasserts the cycle after ack is sampled. Ack must be a single-cycle pulse.
- Misaligned access: response valid 1 cycle after the final handshake.
- Back-to-back: a new AW/W/AR handshake is possible the cycle after the B/R handshake completes.
- bvalid/rvalid never drop before bready/rready; payload is held meanwhile.

## Configuration
- AXIL_TIMEOUT_EN defined:
  - Each REQ state runs a counter from 0.
  - If the counter reaches TIMEOUT_CYCLES with no ack, the request drops and the response is SLVERR (rdata=0).
  - An ack in the same cycle as expiry wins.
- AXIL_TIMEOUT_EN undefined: no counters; REQ waits indefinitely.

## Structure
- Package axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write FSM state encodings: W_IDLE, W_REQ, W_RESP, with AW/W held tracked as two flags.
  - Read FSM state encodings: R_IDLE, R_REQ, R_RESP.
- Sub-module axil_req_timer (start/clear, expire) is instantiated once per path. It is present only under AXIL_TIMEOUT_EN.

## Test plan
- AW+W same cycle, awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, ack next cycle, err=0 → user_wr_req 1 cycle with the same payload; bvalid 2 cycles after the handshake; bresp=00.
- W first, AW 3 cycles later, awaddr=0x20 → wready low after the W handshake; request only after AW; payload correct.
- AR 0x04, ack after 5 cycles with data 0x12345678, err=1 → rvalid with rdata=0x12345678, rresp=10; rvalid held while rready=0 for 4 cycles.
- awaddr=0x03 and araddr=0x06 → no user requests; bresp=rresp=10, rdata=0, 1 cycle after the handshake.
- With AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack → request drops after 16 cycles; SLVERR on B and on R. A separate case with ack at cycle 16 → OKAY.
- aresetn asserted while in W_REQ and R_RESP → all outputs 0 immediately; after release, a fresh write completes normally.
